// File: rtl/rxd_if.sv
// Sample/decision bus of the BPSK receiver. The master side feeds samples and
// observes decisions; the slave side is the receiver itself.
interface rxd_if #(
    parameter int SPS = 16
);
    localparam int CW = 16 + $clog2(SPS);

    logic signed [15:0]   rxd_sig;
    logic                 rxd_valid;
    logic signed [CW-1:0] corr_out;
    logic                 bit_out;
    logic                 bit_valid;
    logic [7:0]           data_out;
    logic                 data_valid;
    logic                 sync_lock;

    modport master (
        output rxd_sig, rxd_valid,
        input  corr_out, bit_out, bit_valid, data_out, data_valid, sync_lock
    );

    modport slave (
        input  rxd_sig, rxd_valid,
        output corr_out, bit_out, bit_valid, data_out, data_valid, sync_lock
    );
endinterface

// File: rtl/rxd.sv
// BPSK receiver: per-symbol square-wave correlator, hard bit decision,
// sync-word hunt and MSB-first payload byte framing.
module rxd #(
    parameter int          SPS       = 16,
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int          FRAME_LEN = 4
) (
    input  logic clk_sig,
    input  logic rst_n,
    rxd_if.slave bus
);
    localparam int IW = $clog2(SPS);
    localparam int CW = 16 + IW;

    typedef enum logic {HUNT, DATA} state_t;

    state_t               state, state_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic signed [CW-1:0] acc, acc_nx;
    logic signed [CW-1:0] term, sum;
    logic signed [CW-1:0] corr, corr_nx;
    logic                 dbit, sym_end;
    logic                 bit_q, bit_nx;
    logic                 bv_q, bv_nx;
    logic [7:0]           sr, sr_nx;
    logic [3:0]           hunt, hunt_nx;
    logic [2:0]           bitcnt, bitcnt_nx;
    logic [7:0]           bytecnt, bytecnt_nx;
    logic [7:0]           dout, dout_nx;
    logic                 dv_q, dv_nx;
    logic                 lock_q, lock_nx;
    logic                 last_byte;

    // Reference is +1 for the first half of the symbol, -1 for the second;
    // SPS is a power of two so the index MSB selects the half.
    always_comb begin
        term    = idx[IW-1] ? -CW'(bus.rxd_sig) : CW'(bus.rxd_sig);
        sum     = acc + term;
        sym_end = bus.rxd_valid && (&idx);
        dbit    = !sum[CW-1] && (sum != '0);
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        acc_nx     = acc;
        corr_nx    = corr;
        bit_nx     = bit_q;
        bv_nx      = 1'b0;
        sr_nx      = sr;
        hunt_nx    = hunt;
        bitcnt_nx  = bitcnt;
        bytecnt_nx = bytecnt;
        dout_nx    = dout;
        dv_nx      = 1'b0;
        last_byte  = 1'b0;

        if (bus.rxd_valid) begin
            idx_nx = idx + 1'b1;
            acc_nx = sum;
        end

        if (sym_end) begin
            acc_nx  = '0;
            corr_nx = sum;
            bit_nx  = dbit;
            bv_nx   = 1'b1;
            sr_nx   = {sr[6:0], dbit};
            case (state)
                HUNT: begin
                    hunt_nx = (hunt == 4'd8) ? 4'd8 : hunt + 4'd1;
                    if (hunt_nx == 4'd8 && sr_nx == SYNC_WORD) begin
                        state_nx   = DATA;
                        hunt_nx    = '0;
                        bitcnt_nx  = '0;
                        bytecnt_nx = '0;
                    end
                end
                DATA: begin
                    bitcnt_nx = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        dout_nx = sr_nx;
                        dv_nx   = 1'b1;
                        if (bytecnt == 8'(FRAME_LEN - 1)) begin
                            state_nx   = HUNT;
                            sr_nx      = '0;
                            hunt_nx    = '0;
                            bytecnt_nx = '0;
                            last_byte  = 1'b1;
                        end else begin
                            bytecnt_nx = bytecnt + 8'd1;
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end

        // Lock stays up through the final byte's data_valid cycle.
        lock_nx = (state_nx == DATA) || last_byte;
    end

    always_ff @(posedge clk_sig) begin
        if (!rst_n) begin
            state   <= HUNT;
            idx     <= '0;
            acc     <= '0;
            corr    <= '0;
            bit_q   <= 1'b0;
            bv_q    <= 1'b0;
            sr      <= '0;
            hunt    <= '0;
            bitcnt  <= '0;
            bytecnt <= '0;
            dout    <= '0;
            dv_q    <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            acc     <= acc_nx;
            corr    <= corr_nx;
            bit_q   <= bit_nx;
            bv_q    <= bv_nx;
            sr      <= sr_nx;
            hunt    <= hunt_nx;
            bitcnt  <= bitcnt_nx;
            bytecnt <= bytecnt_nx;
            dout    <= dout_nx;
            dv_q    <= dv_nx;
            lock_q  <= lock_nx;
        end
    end

    assign bus.corr_out   = corr;
    assign bus.bit_out    = bit_q;
    assign bus.bit_valid  = bv_q;
    assign bus.data_out   = dout;
    assign bus.data_valid = dv_q;
    assign bus.sync_lock  = lock_q;
endmodule

// File: tb/tb_rxd.sv
// Directed bench for rxd: correlator values, bit decisions, sync lock and
// payload framing, with gapped valid and mid-frame reset.
module tb_rxd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   gap = 1'b0;
    logic [7:0] dq[$];

    rxd_if #(.SPS(16)) bus ();

    rxd #(.SPS(16), .SYNC_WORD(8'hA5), .FRAME_LEN(4)) dut (
        .clk_sig(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // data_valid is a full-cycle pulse, so exactly one falling edge sees it
    always @(negedge clk) if (bus.data_valid === 1'b1) dq.push_back(bus.data_out);

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) begin
            @(negedge clk);
            bus.rxd_sig   = 16'($urandom);
            bus.rxd_valid = 1'($urandom);
        end
        @(posedge clk); #1;
        chk("rst_corr", $signed(bus.corr_out), 0);
        chk("rst_bit", bus.bit_out, 0);
        chk("rst_bv", bus.bit_valid, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_dv", bus.data_valid, 0);
        chk("rst_lock", bus.sync_lock, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rxd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rxd_valid = 1'b0;
            bus.rxd_sig   = 16'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_sample(input logic signed [15:0] v);
        if (gap) idle(1);
        @(negedge clk);
        bus.rxd_sig   = v;
        bus.rxd_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_sym(input logic signed [15:0] a, input logic signed [15:0] b,
                            input int exp_corr, input string tag);
        for (int i = 0; i < 16; i++) begin
            send_sample(i < 8 ? a : b);
            if (i == 14) chk({tag, "_bv_early"}, bus.bit_valid, 0);
        end
        chk({tag, "_bv"}, bus.bit_valid, 1);
        chk({tag, "_corr"}, $signed(bus.corr_out), exp_corr);
        chk({tag, "_bit"}, bus.bit_out, (exp_corr > 0) ? 1 : 0);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_sym(16'sd1000, -16'sd1000, 16000, "b1");
        else   send_sym(-16'sd1000, 16'sd1000, -16000, "b0");
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic sync_in(input string tag);
        logic [7:0] sw;
        sw = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(sw[i]);
        chk({tag, "_lock_pre"}, bus.sync_lock, 0);
        send_bit(sw[0]);
        chk({tag, "_lock_rise"}, bus.sync_lock, 1);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, dq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk({tag, "_byte"}, (i < dq.size()) ? dq[i] : 8'hxx, e[i]);
        dq.delete();
    endtask

    initial begin
        bus.rxd_sig   = '0;
        bus.rxd_valid = 1'b0;

        do_reset(2);

        // single symbols
        send_sym(16'sd1000, -16'sd1000, 16000, "sym_pos");
        send_sym(-16'sd1000, 16'sd1000, -16000, "sym_neg");
        send_sym(16'sd0, 16'sd0, 0, "sym_zero");
        send_sym(-16'sd32768, 16'sd32767, -524280, "sym_full");
        send_sym(-16'sd32768, -16'sd32768, 0, "sym_minall");
        send_sym(-16'sd32768, 16'sd32767, -524280, "sym_full2");
        idle(3);
        chk("hold_bv", bus.bit_valid, 0);
        chk("hold_corr", $signed(bus.corr_out), -524280);

        // full frame, relock, payload equal to sync word
        do_reset(2);
        sync_in("f1");
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        chk("f1_dv_last", bus.data_valid, 1);
        chk("f1_dout_last", bus.data_out, 8'h78);
        chk("f1_lock_last", bus.sync_lock, 1);
        idle(1);
        chk("f1_lock_fall", bus.sync_lock, 0);
        chk("f1_dv_end", bus.data_valid, 0);
        check_bytes("f1", 8'h12, 8'h34, 8'h56, 8'h78);

        sync_in("f2");
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        idle(1);
        chk("f2_lock_fall", bus.sync_lock, 0);
        check_bytes("f2", 8'hA5, 8'h00, 8'hFF, 8'h5A);

        // same frame with rxd_valid low every other cycle
        do_reset(2);
        gap = 1'b1;
        sync_in("g");
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        gap = 1'b0;
        idle(1);
        chk("g_lock_fall", bus.sync_lock, 0);
        check_bytes("g", 8'h12, 8'h34, 8'h56, 8'h78);

        // reset after byte 2, mid-symbol
        do_reset(2);
        sync_in("r");
        send_byte(8'h12);
        send_byte(8'h34);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_sample(16'sd1000);
        do_reset(1);
        chk("r_count_mid", dq.size(), 2);
        dq.delete();
        send_byte(8'h56);
        send_byte(8'h78);
        idle(2);
        chk("r_no_dv", dq.size(), 0);
        chk("r_no_lock", bus.sync_lock, 0);
        sync_in("r2");
        send_byte(8'h9C);
        send_byte(8'h3E);
        send_byte(8'h01);
        send_byte(8'h80);
        idle(1);
        check_bytes("r2", 8'h9C, 8'h3E, 8'h01, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rxd.md
RXD -- requirements
Module: rxd

Interface
REQ-001 Parameter SPS, default 16, samples per symbol; power of two, 4 to 64.
REQ-002 Parameter SYNC_WORD, default 8'hA5, frame sync pattern, MSB received first.
REQ-003 Parameter FRAME_LEN, default 4, payload bytes per frame after sync, 1 to 255.
REQ-004 clk_sig  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 rxd_sig  input  16  signed two's-complement BPSK sample, same format as the txd_sig output of txd.
REQ-007 rxd_valid  input  1  qualifies rxd_sig on the current cycle.
REQ-008 corr_out  output  16+log2(SPS)  signed correlation result of the last completed symbol.
REQ-009 bit_out  output  1  decided bit of the last completed symbol.
REQ-010 bit_valid  output  1  one-cycle pulse per decided symbol.
REQ-011 data_out  output  8  last completed payload byte.
REQ-012 data_valid  output  1  one-cycle pulse per payload byte.
REQ-013 sync_lock  output  1  high while inside a frame (DATA state).

Function
REQ-014 A sample index counts 0..SPS-1 and advances only on cycles with rxd_valid=1; it wraps from SPS-1 to 0.
REQ-015 Reference sign is +1 for index 0..SPS/2-1 and -1 for index SPS/2..SPS-1; each valid sample is multiplied by that sign and added to an accumulator of width 16+log2(SPS).
REQ-016 The accumulator is wide enough for all inputs; no saturation and no wrap, including with every sample at -32768.
REQ-017 On the edge that accepts the sample at index SPS-1, corr_out is loaded with the final sum including that sample, the accumulator restarts from 0, and bit_valid is high for exactly the following cycle.
REQ-018 bit_out=1 iff the final sum > 0; a sum of 0 or less gives bit_out=0.
REQ-019 With rxd_valid=0, the accumulator, sample index, and all state are held, and no pulses are generated.
REQ-020 An 8-bit shift register takes each decided bit at the LSB, shifting toward the MSB; a hunt counter saturates at 8.
REQ-021 State HUNT: on a decided bit, if the hunt counter (including this bit) is at least 8 and the updated shift register equals SYNC_WORD, go to DATA. sync_lock rises in the same cycle as that bit's bit_valid.
REQ-022 State DATA: decided bits are packed MSB first. On the 8th bit, data_out updates and data_valid pulses in the same cycle as that bit's bit_valid.
REQ-023 After the FRAME_LEN-th byte, return to HUNT: sync_lock falls in the same cycle as that data_valid pulse ends; the shift register and hunt counter clear to 0.
REQ-024 Sync matching is inactive in DATA; a payload byte equal to SYNC_WORD is delivered as data.
REQ-025 bit_valid and corr_out operate in every state.

Reset
REQ-026 When rst_n=0 at a clock edge, the following clear to 0: corr_out, bit_out, bit_valid, data_out, data_valid, sync_lock, the accumulator, sample index, shift register, hunt counter, and byte/bit counters. State returns to HUNT.
REQ-027 Reset mid-symbol or mid-frame discards partial results. No data_valid is emitted for a partial byte, and a new full sync is required.

Verification
REQ-028 Reset: hold rst_n=0 for 2 cycles with random rxd_sig -> every output is 0 and sync_lock=0.
REQ-029 Single symbol, SPS=16: +1000 at indices 0-7 and -1000 at 8-15 -> corr_out=16000 and bit_out=1, with bit_valid high 1 cycle after the 16th sample. Inverted samples -> corr_out=-16000, bit_out=0. All-zero samples -> corr_out=0, bit_out=0.
REQ-030 Full scale: -32768 at indices 0-7 and +32767 at 8-15 -> corr_out=-524280 with no wrap, bit_out=0.
REQ-031 Frame: bits 0xA5, then 0x12, 0x34, 0x56, 0x78 -> sync_lock rises with the 8th sync bit; data_valid pulses 4 times with those values; sync_lock drops after 0x78. A following 0xA5 relocks only after 8 new bits.
REQ-032 rxd_valid toggled every other cycle during the REQ-031 stream -> identical bytes and corr_out values, only spread in time.
REQ-033 rst_n=0 for 1 cycle after byte 2 of a frame -> sync_lock=0 immediately, no further data_valid until a fresh 0xA5 is received.
